// File: rtl/unit_spawn_scheduler.sv
// unit_spawn_scheduler: central controller for the friendly unit slots.
// Places purchases on the lowest free slot, charges gold, generates the
// game-tick strobes and reports the friendly front line.
//
// Handshake: purchaseBtn is a single-cycle request sampled only in IDLE.
// A request is answered by either one purchase strobe or one reject pulse,
// and busy stays high until the scheduler can accept the next request.
// There is no queuing, so requests made while busy are dropped.
module unit_spawn_scheduler #(
  parameter int NUM_UNITS   = 4,
  parameter int TICK_PERIOD = 1000000,
  parameter int COST1       = 10,
  parameter int COST2       = 20,
  parameter int COST3       = 40,
  parameter int INCOME      = 1,
  parameter int GOLD_MAX    = 999,
  parameter int START_GOLD  = 50,
  parameter int COOLDOWN    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   purchaseBtn,
  input  logic                   SW1,
  input  logic                   SW2,
  input  logic                   SW3,
  input  logic [2*NUM_UNITS-1:0] unitTypes,
  input  logic [9*NUM_UNITS-1:0] positions,
  output logic [NUM_UNITS-1:0]   purchase,
  output logic [2:0]             typeSel,
  output logic                   moveSCEN,
  output logic                   damageSCEN,
  output logic [9:0]             gold,
  output logic [8:0]             friendlyFront,
  output logic                   reject,
  output logic                   busy
);

  localparam int CNT_W  = $clog2(TICK_PERIOD);
  localparam int COOL_W = $clog2(COOLDOWN + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_PERIOD - 1);
  localparam logic [COOL_W-1:0] COOL_END = COOL_W'(COOLDOWN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    GRANT = 2'd2,
    COOL  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   move_q, move_d;
  logic                   damage_q, damage_d;
  logic [9:0]             gold_q, gold_d;
  logic [2:0]             type_sel_q, type_sel_d;
  logic [NUM_UNITS-1:0]   purchase_q, purchase_d;
  logic                   reject_q, reject_d;
  logic                   busy_q, busy_d;
  logic [11:0]            cost_q, cost_d;
  logic [COOL_W-1:0]      cool_q, cool_d;
  logic [8:0]             front_q, front_d;

  logic [NUM_UNITS-1:0]   free_onehot;
  logic                   free_found;
  logic [11:0]            sel_cost;
  logic [11:0]            gold_sum;
  logic [2:0]             sw_now;

  assign sw_now = {SW1, SW2, SW3};

  // Free-running tick counter; moveSCEN follows the last count, damageSCEN follows moveSCEN.
  always_comb begin
    cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    move_d   = (cnt_q == CNT_LAST);
    damage_d = move_q;
  end

  // Lowest-indexed free slot, taken straight from the live unitTypes bus.
  always_comb begin
    free_onehot = '0;
    free_found  = 1'b0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (unitTypes[2*i +: 2] == 2'b00) begin
        free_onehot    = '0;
        free_onehot[i] = 1'b1;
        free_found     = 1'b1;
      end
    end
  end

  // Price of the latched unit type.
  always_comb begin
    sel_cost = 12'd0;
    case (type_sel_q)
      3'b100:  sel_cost = 12'(COST1);
      3'b010:  sel_cost = 12'(COST2);
      3'b001:  sel_cost = 12'(COST3);
      default: sel_cost = 12'd0;
    endcase
  end

  // Gold: charge on GRANT, add income on the moveSCEN cycle, saturate at GOLD_MAX.
  // Subtracting first is safe because CHECK already guaranteed gold >= cost.
  always_comb begin
    gold_sum = {2'b00, gold_q};
    if (state_q == GRANT) gold_sum = gold_sum - cost_q;
    if (move_q)           gold_sum = gold_sum + 12'(INCOME);
    gold_d = (gold_sum > 12'(GOLD_MAX)) ? 10'(GOLD_MAX) : gold_sum[9:0];
  end

  // Purchase FSM: next state and registered outputs.
  // COOL runs its counter 0..COOLDOWN, giving COOLDOWN lockout cycles plus the exit cycle.
  always_comb begin
    state_d    = state_q;
    type_sel_d = type_sel_q;
    purchase_d = '0;
    reject_d   = 1'b0;
    cost_d     = cost_q;
    cool_d     = cool_q;
    case (state_q)
      IDLE: begin
        if (purchaseBtn) begin
          type_sel_d = sw_now;
          case (sw_now)
            3'b100, 3'b010, 3'b001: state_d  = CHECK;
            default:                reject_d = 1'b1;
          endcase
        end
      end
      CHECK: begin
        if (!free_found || ({2'b00, gold_q} < sel_cost)) begin
          reject_d = 1'b1;
          state_d  = IDLE;
        end else begin
          purchase_d = free_onehot;
          cost_d     = sel_cost;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        cool_d  = '0;
        state_d = COOL;
      end
      COOL: begin
        if (cool_q == COOL_END) state_d = IDLE;
        else                    cool_d  = cool_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Friendly front: minimum position over alive slots, all-ones when none alive.
  always_comb begin
    front_d = 9'h1FF;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (unitTypes[2*i +: 2] != 2'b00 && positions[9*i +: 9] < front_d) begin
        front_d = positions[9*i +: 9];
      end
    end
  end

  // State and output registers; reset aborts any grant in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      move_q     <= 1'b0;
      damage_q   <= 1'b0;
      gold_q     <= 10'(START_GOLD);
      type_sel_q <= 3'b000;
      purchase_q <= '0;
      reject_q   <= 1'b0;
      busy_q     <= 1'b0;
      cost_q     <= '0;
      cool_q     <= '0;
      front_q    <= 9'h1FF;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      move_q     <= move_d;
      damage_q   <= damage_d;
      gold_q     <= gold_d;
      type_sel_q <= type_sel_d;
      purchase_q <= purchase_d;
      reject_q   <= reject_d;
      busy_q     <= busy_d;
      cost_q     <= cost_d;
      cool_q     <= cool_d;
      front_q    <= front_d;
    end
  end

  assign purchase      = purchase_q;
  assign typeSel       = type_sel_q;
  assign moveSCEN      = move_q;
  assign damageSCEN    = damage_q;
  assign gold          = gold_q;
  assign friendlyFront = front_q;
  assign reject        = reject_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_unit_spawn_scheduler.sv
// Self-checking bench for unit_spawn_scheduler: directed scenarios followed
// by randomized purchases, compared each cycle against a transaction-level model.
module tb_unit_spawn_scheduler;

  localparam int NU    = 4;
  localparam int TP    = 6;
  localparam int C1    = 10;
  localparam int C2    = 20;
  localparam int C3    = 40;
  localparam int INC   = 5;
  localparam int GMAX  = 999;
  localparam int SGOLD = 50;
  localparam int CD    = 8;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              btn = 1'b0;
  logic              sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0;
  logic [2*NU-1:0]   unit_types = '0;
  logic [9*NU-1:0]   positions_v = '0;
  logic [NU-1:0]     purchase;
  logic [2:0]        type_sel;
  logic              move_scen, damage_scen;
  logic [9:0]        gold;
  logic [8:0]        friendly_front;
  logic              reject, busy;

  unit_spawn_scheduler #(
    .NUM_UNITS(NU), .TICK_PERIOD(TP), .COST1(C1), .COST2(C2), .COST3(C3),
    .INCOME(INC), .GOLD_MAX(GMAX), .START_GOLD(SGOLD), .COOLDOWN(CD)
  ) dut (
    .clk(clk), .reset(rst), .purchaseBtn(btn),
    .SW1(sw1), .SW2(sw2), .SW3(sw3),
    .unitTypes(unit_types), .positions(positions_v),
    .purchase(purchase), .typeSel(type_sel),
    .moveSCEN(move_scen), .damageSCEN(damage_scen),
    .gold(gold), .friendlyFront(friendly_front),
    .reject(reject), .busy(busy)
  );

  // Scoreboard and model state
  int tests_run    = 0;
  int tests_failed = 0;
  logic [NU-1:0] exp_q[$];

  int            edge_n      = 0;
  int            m_gold      = SGOLD;
  int            m_pend_cost = 0;
  logic [NU-1:0] exp_purchase = '0;
  logic          exp_reject   = 1'b0;
  logic          exp_busy     = 1'b0;
  logic [2:0]    exp_tsel     = 3'b000;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] front_of(input logic [2*NU-1:0] t, input logic [9*NU-1:0] p);
    int m = 511;
    for (int i = 0; i < NU; i++)
      if (t[2*i +: 2] != 2'b00 && int'(p[9*i +: 9]) < m) m = int'(p[9*i +: 9]);
    return 9'(m);
  endfunction

  function automatic int lowest_free(input logic [2*NU-1:0] t);
    for (int i = 0; i < NU; i++)
      if (t[2*i +: 2] == 2'b00) return i;
    return -1;
  endfunction

  function automatic int cost_of(input logic [2:0] sw);
    case (sw)
      3'b100:  return C1;
      3'b010:  return C2;
      3'b001:  return C3;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_onehot(input logic [2:0] sw);
    return (sw == 3'b100) || (sw == 3'b010) || (sw == 3'b001);
  endfunction

  // One clock: advance the model across the edge, then compare every output.
  task automatic tick();
    logic [8:0] ff;
    int g;
    bit inc;
    ff = front_of(unit_types, positions_v);
    @(posedge clk);
    edge_n++;
    inc = ((edge_n - 1) > 0) && (((edge_n - 1) % TP) == 0);
    g = m_gold - m_pend_cost + (inc ? INC : 0);
    if (g > GMAX) g = GMAX;
    m_gold = g;
    m_pend_cost = 0;
    #1;
    check_val("moveSCEN",   move_scen,   ((edge_n % TP) == 0));
    check_val("damageSCEN", damage_scen, inc);
    check_val("gold",       gold,        m_gold);
    check_val("front",      friendly_front, ff);
    check_val("purchase",   purchase,    exp_purchase);
    check_val("reject",     reject,      exp_reject);
    check_val("busy",       busy,        exp_busy);
    check_val("typeSel",    type_sel,    exp_tsel);
    if (purchase != '0) begin
      if (exp_q.size() == 0) check_val("grant_unexpected", purchase, 0);
      else                   check_val("grant_q", purchase, exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_val("rst_purchase", purchase,    0);
    check_val("rst_gold",     gold,        SGOLD);
    check_val("rst_typeSel",  type_sel,    0);
    check_val("rst_move",     move_scen,   0);
    check_val("rst_damage",   damage_scen, 0);
    check_val("rst_reject",   reject,      0);
    check_val("rst_busy",     busy,        0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    edge_n = 0; m_gold = SGOLD; m_pend_cost = 0;
    exp_purchase = '0; exp_reject = 1'b0; exp_busy = 1'b0; exp_tsel = 3'b000;
  endtask

  // Driver: one purchase request. ut_chk is what unitTypes shows during CHECK;
  // noise pokes the button while busy; rst_grant resets in the GRANT cycle.
  task automatic do_txn(input logic [2:0] sw, input logic [2*NU-1:0] ut_chk,
                        input bit noise, input bit rst_grant);
    int slot, cost;
    {sw1, sw2, sw3} = sw;
    btn = 1'b1;
    exp_tsel = sw;
    if (is_onehot(sw)) exp_busy = 1'b1;
    else               exp_reject = 1'b1;
    tick();
    btn = 1'b0;
    {sw1, sw2, sw3} = 3'($urandom_range(0, 7));
    if (!is_onehot(sw)) begin
      exp_reject = 1'b0;
      tick();
      return;
    end
    unit_types = ut_chk;
    slot = lowest_free(ut_chk);
    cost = cost_of(sw);
    if (slot < 0 || m_gold < cost) begin
      exp_reject = 1'b1; exp_busy = 1'b0;
      tick();
      exp_reject = 1'b0;
      tick();
      return;
    end
    exp_purchase = NU'(1) << slot;
    exp_q.push_back(NU'(1) << slot);
    tick();
    exp_purchase = '0;
    if (rst_grant) begin
      #2;
      do_reset();
      return;
    end
    m_pend_cost = cost;
    for (int k = 0; k <= CD; k++) begin
      if (noise) begin
        btn = 1'($urandom_range(0, 1));
        {sw1, sw2, sw3} = 3'($urandom_range(0, 7));
      end
      tick();
    end
    btn = 1'b0;
    exp_busy = 1'b0;
    tick();
  endtask

  task automatic idle(input int n, input bit scramble);
    for (int k = 0; k < n; k++) begin
      if (scramble) begin
        unit_types  = 2*NU'($urandom);
        positions_v = {$urandom, $urandom};
      end
      tick();
    end
  endtask

  initial begin
    #2;
    do_reset();
    idle(2, 1'b0);

    // Empty board, type 1 goes to slot 0
    unit_types = '0;
    do_txn(3'b100, 8'h00, 1'b0, 1'b0);
    // Slots 0 and 1 occupied, type 3 goes to slot 2
    do_txn(3'b001, 8'h05, 1'b0, 1'b0);
    // Invalid selections rejected from IDLE
    do_txn(3'b110, 8'h00, 1'b0, 1'b0);
    do_txn(3'b000, 8'h00, 1'b0, 1'b0);
    do_txn(3'b111, 8'h00, 1'b0, 1'b0);
    // All slots occupied, then slot 2 frees up
    do_txn(3'b100, 8'hFF, 1'b0, 1'b0);
    do_txn(3'b100, 8'hCF, 1'b0, 1'b0);

    // Front line: alive {300,120,dead,200} then all dead
    unit_types  = 8'b01_00_01_01;
    positions_v = {9'd200, 9'd77, 9'd120, 9'd300};
    idle(2, 1'b0);
    unit_types = '0;
    idle(2, 1'b0);

    // Drain gold with expensive units until refused
    for (int k = 0; k < 6; k++) do_txn(3'b001, 8'h00, 1'b0, 1'b0);

    // Accumulate up to the ceiling
    idle(1300, 1'b0);
    do_txn(3'b100, 8'h40, 1'b1, 1'b0);

    // Randomized purchases
    for (int k = 0; k < 60; k++) begin
      logic [2:0] sw;
      sw = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                       : (3'b001 << $urandom_range(0, 2));
      unit_types  = 2*NU'($urandom);
      positions_v = {$urandom, $urandom};
      do_txn(sw, 2*NU'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      idle($urandom_range(0, 4), 1'b1);
    end

    // Reset during GRANT
    unit_types = '0;
    do_txn(3'b100, 8'h00, 1'b0, 1'b1);
    idle(3, 1'b1);
    for (int k = 0; k < 20; k++) begin
      unit_types = 2*NU'($urandom);
      do_txn(3'b001 << $urandom_range(0, 2), 2*NU'($urandom), 1'b1, 1'b0);
    end

    check_val("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
